// File: rtl/full_dm_rf_alu_pkg.sv
// Shared encodings for the execute/memory/write-back slice: ALUOp values,
// R-type function codes and the internal ALU operation select.
package full_dm_rf_alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h2;
    localparam logic [3:0] F_AND = 4'h4;
    localparam logic [3:0] F_OR  = 4'h5;
    localparam logic [3:0] F_SLT = 4'hA;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NOP
    } alu_ctl_e;

endpackage

// File: rtl/full_dm_rf_alu_alu_core.sv
// ALU-control decode plus the ALU itself; purely combinational.
module alu_core
    import full_dm_rf_alu_pkg::*;
#(
    parameter int DATA_W = full_dm_rf_alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        func,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output alu_ctl_e          ctl
);

    always_comb begin
        ctl = ALU_NOP;
        case (alu_op)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            default: begin
                // Both 10 and 11 take the operation from the function field.
                case (func)
                    F_ADD:   ctl = ALU_ADD;
                    F_SUB:   ctl = ALU_SUB;
                    F_AND:   ctl = ALU_AND;
                    F_OR:    ctl = ALU_OR;
                    F_SLT:   ctl = ALU_SLT;
                    default: ctl = ALU_NOP;
                endcase
            end
        endcase
    end

    always_comb begin
        result = '0;
        case (ctl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/full_dm_rf_alu.sv
// Single-cycle execute/memory/write-back slice: 32x32 register file,
// sign extender, ALU and word-addressed data memory.
module full_dm_rf_alu
    import full_dm_rf_alu_pkg::*;
#(
    parameter int DATA_W    = full_dm_rf_alu_pkg::DATA_W,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       SEin,
    input  logic [5:0]        FuncCode,
    input  logic              Regsel,
    input  logic              ALUsel,
    input  logic [1:0]        ALUOp,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              MemToRegSel,
    input  logic              RegWrite,
    output logic              Zero,
    output logic [DATA_W-1:0] ALUOut
);

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] sign_ext;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] wb_data;
    logic [MEM_AW-1:0] mem_addr;
    logic [4:0]        wr_addr;
    alu_ctl_e          alu_ctl;
    logic              unused_bits;

    assign rd_a     = (rs == 5'd0) ? '0 : regs[rs];
    assign rd_b     = (rt == 5'd0) ? '0 : regs[rt];
    assign sign_ext = {{(DATA_W-16){SEin[15]}}, SEin};
    assign alu_b    = ALUsel ? sign_ext : rd_b;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (rd_a),
        .b      (alu_b),
        .alu_op (ALUOp),
        .func   (FuncCode[3:0]),
        .result (ALUOut),
        .zero   (Zero),
        .ctl    (alu_ctl)
    );

    // Byte offset and high address bits are dropped, so addresses wrap.
    assign mem_addr  = ALUOut[MEM_AW+1:2];
    assign mem_rdata = MemRead ? mem[mem_addr] : '0;
    assign wb_data   = MemToRegSel ? mem_rdata : ALUOut;
    assign wr_addr   = Regsel ? rd : rt;

    assign unused_bits = ^{FuncCode[5:4], ALUOut[1:0], ALUOut[DATA_W-1:MEM_AW+2], alu_ctl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite) begin
            mem[mem_addr] <= rd_b;
        end
    end

endmodule

// File: tb/tb_full_dm_rf_alu.sv
// Directed-vector bench for full_dm_rf_alu; registers are observed through
// the ALU by adding zero to the register under inspection.
module tb_full_dm_rf_alu;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [5:0]  FuncCode;
    logic        Regsel, ALUsel;
    logic [1:0]  ALUOp;
    logic        MemWrite, MemRead, MemToRegSel, RegWrite;
    logic        Zero;
    logic [31:0] ALUOut;

    int total = 0;
    int bad   = 0;

    full_dm_rf_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .SEin        (SEin),
        .FuncCode    (FuncCode),
        .Regsel      (Regsel),
        .ALUsel      (ALUsel),
        .ALUOp       (ALUOp),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemToRegSel (MemToRegSel),
        .RegWrite    (RegWrite),
        .Zero        (Zero),
        .ALUOut      (ALUOut)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs = 0; rt = 0; rd = 0; SEin = 0; FuncCode = 0;
        Regsel = 0; ALUsel = 0; ALUOp = 2'b00;
        MemWrite = 0; MemRead = 0; MemToRegSel = 0; RegWrite = 0;
    endtask

    // Advance one edge; inputs are changed 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        idle();
        rs = idx; ALUsel = 1; SEin = 0; ALUOp = 2'b00;
        #1;
        check(tag, ALUOut, exp);
    endtask

    task automatic load_imm(input logic [4:0] dst, input logic [15:0] imm);
        idle();
        rt = dst; SEin = imm; ALUsel = 1; RegWrite = 1;
        step();
    endtask

    task automatic rtype(input logic [5:0] func, input logic [31:0] exp, input logic exp_zero,
                         input string tag);
        idle();
        rs = 1; rt = 2; rd = 3; Regsel = 1; ALUsel = 0; ALUOp = 2'b10;
        FuncCode = func; RegWrite = 1;
        #1;
        check(tag, ALUOut, exp);
        check({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp_zero});
        step();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        peek_reg(5'd1, 32'd0, "reset_r1");
        check("reset_zero", {31'd0, Zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // immediate loads
        idle();
        rt = 1; SEin = 16'h0014; ALUsel = 1; RegWrite = 1;
        #1;
        check("li_r1_aluout", ALUOut, 32'h14);
        step();
        peek_reg(5'd1, 32'd20, "li_r1");
        load_imm(5'd2, 16'h0028);
        peek_reg(5'd2, 32'd40, "li_r2");

        // R-type sweep, R1=20 R2=40
        rtype(6'h00, 32'd60,         1'b0, "r_add");
        rtype(6'h02, 32'hFFFF_FFEC,  1'b0, "r_sub");
        rtype(6'h04, 32'd0,          1'b1, "r_and");
        rtype(6'h05, 32'd60,         1'b0, "r_or");
        rtype(6'h22, 32'hFFFF_FFEC,  1'b0, "r_sub_hibits");
        rtype(6'h3F, 32'd0,          1'b1, "r_badfunc");
        rtype(6'h0A, 32'd1,          1'b0, "r_slt");
        peek_reg(5'd3, 32'd1, "r3_last");

        // sign extension
        idle();
        rs = 1; SEin = 16'hFFFF; ALUsel = 1; ALUOp = 2'b00;
        #1;
        check("se_add", ALUOut, 32'd19);
        ALUOp = 2'b01;
        #1;
        check("se_sub", ALUOut, 32'd21);
        ALUOp = 2'b11; FuncCode = 6'h00;
        #1;
        check("op11_add", ALUOut, 32'd19);

        // signed slt and wrap-around
        load_imm(5'd6, 16'hFFFF);
        idle();
        rs = 6; ALUsel = 1; SEin = 16'h0000; ALUOp = 2'b10; FuncCode = 6'h0A;
        #1;
        check("slt_signed", ALUOut, 32'd1);
        ALUOp = 2'b00; SEin = 16'h0001;
        #1;
        check("add_wrap", ALUOut, 32'd0);
        check("add_wrap_zero", {31'd0, Zero}, 32'd1);

        // store R2 to word 2, then load it into R4
        idle();
        rt = 2; SEin = 16'h0008; ALUsel = 1; MemWrite = 1;
        #1;
        check("st_addr", ALUOut, 32'd8);
        step();
        idle();
        rt = 4; SEin = 16'h0008; ALUsel = 1; MemRead = 1; MemToRegSel = 1; RegWrite = 1;
        step();
        peek_reg(5'd4, 32'd40, "ld_r4");

        // address wraps modulo depth: 0x408 maps to word 2
        idle();
        rt = 7; SEin = 16'h0408; ALUsel = 1; MemRead = 1; MemToRegSel = 1; RegWrite = 1;
        step();
        peek_reg(5'd7, 32'd40, "ld_wrap");

        // MemRead low gives zero read data
        idle();
        rt = 4; SEin = 16'h0008; ALUsel = 1; MemRead = 0; MemToRegSel = 1; RegWrite = 1;
        step();
        peek_reg(5'd4, 32'd0, "ld_noread");

        // same-edge store of R1 and load of old word into R9
        idle();
        rt = 1; rd = 9; Regsel = 1; SEin = 16'h0008; ALUsel = 1;
        MemWrite = 1; MemRead = 1; MemToRegSel = 1; RegWrite = 1;
        step();
        peek_reg(5'd9, 32'd40, "rw_old_data");
        idle();
        rt = 10; SEin = 16'h0008; ALUsel = 1; MemRead = 1; MemToRegSel = 1; RegWrite = 1;
        step();
        peek_reg(5'd10, 32'd20, "rw_new_data");

        // register 0 ignores writes
        idle();
        rt = 0; SEin = 16'h0055; ALUsel = 1; RegWrite = 1;
        #1;
        check("r0_aluout", ALUOut, 32'h55);
        step();
        peek_reg(5'd0, 32'd0, "r0_stays");

        // write-before-read on R5
        load_imm(5'd5, 16'h0010);
        idle();
        rs = 5; rd = 5; Regsel = 1; SEin = 16'h0077; ALUsel = 1; RegWrite = 1;
        #1;
        check("r5_before_edge", ALUOut, 32'h87);
        step();
        check("r5_after_edge", ALUOut, 32'hFE);

        // asynchronous reset between edges
        peek_reg(5'd1, 32'd20, "r1_pre_reset");
        rst_n = 1'b0;
        #1;
        check("async_rst_r1", ALUOut, 32'd0);
        check("async_rst_zero", {31'd0, Zero}, 32'd1);
        peek_reg(5'd2, 32'd0, "async_rst_r2");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
